// File: rtl/led_flow_pwm_pkg.sv
// Shared definitions for the LED flow driver: mode encodings and a
// constant-function width helper usable in port declarations.
package led_pkg;

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FREEZE = 2'd3;

  // Bits needed to count 0..n-1, never less than 1 so a 1-entry range
  // still yields a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_flow_pwm_bank.sv
// PWM output bank: one free-running counter shared by all channels and a
// registered comparator per channel.
//   clk, rst_n  clock / async active-low reset
//   clr         synchronous clear (counter and outputs to 0)
//   duty_flat   N_LED duties, channel i at bits [i*DUTY_W +: DUTY_W]
//   led_out     registered drive, led_out[i] = (pwm_cnt < duty[i])
module led_pwm_bank #(
  parameter int N_LED   = 8,
  parameter int PWM_TOP = 900,
  parameter int DUTY_W  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [N_LED*DUTY_W-1:0]   duty_flat,
  output logic [N_LED-1:0]          led_out
);

  logic [DUTY_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led_out <= '0;
    end else if (clr) begin
      pwm_cnt <= '0;
      led_out <= '0;
    end else begin
      pwm_cnt <= (pwm_cnt == DUTY_W'(PWM_TOP - 1)) ? '0 : pwm_cnt + 1'b1;
      // duty 0 never beats the counter; duty >= PWM_TOP always does.
      for (int i = 0; i < N_LED; i++) begin
        led_out[i] <= (pwm_cnt < duty_flat[i*DUTY_W +: DUTY_W]);
      end
    end
  end

endmodule

// File: rtl/led_flow_pwm.sv
// Water-flow LED driver: a full-brightness head walks across N_LED
// channels (up, down, bounce or frozen) leaving a geometrically fading tail.
//   clk, rst_n   clock / async active-low reset
//   en           run enable; low holds everything cleared
//   mode         0 up, 1 down, 2 bounce, 3 freeze (sampled at step ticks)
//   decay_shift  tail decay strength, 0 clears the tail at once
//   led_out      registered PWM drive per channel
//   head_idx     current head position
//   step_tick    one-cycle pulse at each step boundary
module led_flow_pwm
  import led_pkg::*;
#(
  parameter int N_LED       = 8,
  parameter int PWM_TOP     = 900,
  parameter int DUTY_MAX    = 900,
  parameter int STEP_CYCLES = 30000,
  parameter int DUTY_FLOOR  = 50,
  parameter int DUTY_W      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [2:0]                decay_shift,
  output logic [N_LED-1:0]          led_out,
  output logic [clog2(N_LED)-1:0]   head_idx,
  output logic                      step_tick
);

  localparam int HW = clog2(N_LED);
  localparam int SW = clog2(STEP_CYCLES);
  localparam logic [HW-1:0] HEAD_MAX = HW'(N_LED - 1);

  logic [SW-1:0]           step_cnt;
  logic                    tick;
  logic                    dir_up;
  logic                    eff_up;
  logic                    next_dir_up;
  logic [1:0]              prev_mode;
  logic [HW-1:0]           next_head;
  logic [DUTY_W-1:0]       duty    [N_LED];
  logic [DUTY_W-1:0]       decayed [N_LED];
  logic [N_LED*DUTY_W-1:0] duty_flat;

  assign tick = (step_cnt == SW'(STEP_CYCLES - 1));

  // Bounce direction comes from the mode used at the previous tick:
  // arriving from up/down inherits that direction, otherwise the stored one.
  always_comb begin
    next_head   = head_idx;
    next_dir_up = dir_up;
    eff_up      = dir_up;
    case (mode)
      MODE_UP:   next_head = (head_idx == HEAD_MAX) ? '0 : head_idx + 1'b1;
      MODE_DOWN: next_head = (head_idx == '0) ? HEAD_MAX : head_idx - 1'b1;
      MODE_BOUNCE: begin
        if (prev_mode == MODE_UP)        eff_up = 1'b1;
        else if (prev_mode == MODE_DOWN) eff_up = 1'b0;
        if (eff_up) begin
          if (head_idx == HEAD_MAX) begin
            next_head   = head_idx - 1'b1;
            next_dir_up = 1'b0;
          end else begin
            next_head   = head_idx + 1'b1;
            next_dir_up = 1'b1;
          end
        end else begin
          if (head_idx == '0) begin
            next_head   = head_idx + 1'b1;
            next_dir_up = 1'b1;
          end else begin
            next_head   = head_idx - 1'b1;
            next_dir_up = 1'b0;
          end
        end
      end
      default: next_head = head_idx;
    endcase
  end

  // d - (d >> s) never underflows; small results snap to dark.
  for (genvar g = 0; g < N_LED; g++) begin : g_chan
    logic [DUTY_W-1:0] diff;
    assign diff       = duty[g] - (duty[g] >> decay_shift);
    assign decayed[g] = (decay_shift == 3'd0 || diff < DUTY_W'(DUTY_FLOOR)) ? '0 : diff;
    assign duty_flat[g*DUTY_W +: DUTY_W] = duty[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt  <= '0;
      step_tick <= 1'b0;
      head_idx  <= '0;
      dir_up    <= 1'b1;
      prev_mode <= MODE_UP;
      for (int i = 0; i < N_LED; i++) duty[i] <= '0;
    end else if (!en) begin
      step_cnt  <= '0;
      step_tick <= 1'b0;
      head_idx  <= '0;
      dir_up    <= 1'b1;
      prev_mode <= MODE_UP;
      for (int i = 0; i < N_LED; i++) duty[i] <= '0;
    end else begin
      step_tick <= tick;
      step_cnt  <= tick ? '0 : step_cnt + 1'b1;
      if (tick) begin
        prev_mode <= mode;
        if (mode != MODE_FREEZE) begin
          head_idx <= next_head;
          dir_up   <= next_dir_up;
          for (int i = 0; i < N_LED; i++) begin
            duty[i] <= (HW'(i) == next_head) ? DUTY_W'(DUTY_MAX) : decayed[i];
          end
        end
      end
    end
  end

  led_pwm_bank #(
    .N_LED   (N_LED),
    .PWM_TOP (PWM_TOP),
    .DUTY_W  (DUTY_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (~en),
    .duty_flat (duty_flat),
    .led_out   (led_out)
  );

endmodule

// File: tb/tb_led_flow_pwm.sv
module tb_led_flow_pwm;
  import led_pkg::*;

  localparam int N     = 8;
  localparam int PT    = 1000;
  localparam int DMAX  = 900;
  localparam int SC    = 1200;
  localparam int FLOOR = 50;
  localparam int DW    = 10;
  localparam int HW    = clog2(N);
  localparam int NV    = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [2:0]    shift = 3'd1;
  logic [N-1:0]  led_out;
  logic [HW-1:0] head_idx;
  logic          step_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = 0;
  int on_cnt [N];
  int win_ticks;

  led_flow_pwm #(
    .N_LED(N), .PWM_TOP(PT), .DUTY_MAX(DMAX), .STEP_CYCLES(SC),
    .DUTY_FLOOR(FLOOR), .DUTY_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .decay_shift(shift),
    .led_out(led_out), .head_idx(head_idx), .step_tick(step_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] shift;
    int         head;
    int         ch;
    int         on;
    bit         only_head;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (n < 3*SC) begin
      @(negedge clk);
      n++;
      if (step_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no step_tick within %0d cycles", name, 3*SC);
    end
  endtask

  // One full PWM period of samples: each counter value appears once, so
  // the high count of a channel equals its duty (capped at PT).
  task automatic measure();
    for (int c = 0; c < N; c++) on_cnt[c] = 0;
    win_ticks = 0;
    for (int k = 0; k < PT; k++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) if (led_out[c] === 1'b1) on_cnt[c]++;
      if (step_tick !== 1'b0) win_ticks++;
    end
  endtask

  initial begin
    int others;
    //           mode  shift head ch  on   only_head
    vecs[0]  = '{2'd0, 3'd1, 1, 1, 900, 1'b1};
    vecs[1]  = '{2'd0, 3'd1, 2, 1, 450, 1'b0};
    vecs[2]  = '{2'd0, 3'd1, 3, 1, 225, 1'b0};
    vecs[3]  = '{2'd0, 3'd1, 4, 1, 113, 1'b0};
    vecs[4]  = '{2'd0, 3'd1, 5, 1,  57, 1'b0};
    vecs[5]  = '{2'd0, 3'd1, 6, 1,   0, 1'b0};
    vecs[6]  = '{2'd0, 3'd1, 7, 5, 225, 1'b0};
    vecs[7]  = '{2'd2, 3'd1, 6, 7, 450, 1'b0};
    vecs[8]  = '{2'd2, 3'd1, 5, 6, 450, 1'b0};
    vecs[9]  = '{2'd2, 3'd1, 4, 6, 225, 1'b0};
    vecs[10] = '{2'd2, 3'd1, 3, 6, 113, 1'b0};
    vecs[11] = '{2'd2, 3'd1, 2, 6,  57, 1'b0};
    vecs[12] = '{2'd2, 3'd1, 1, 6,   0, 1'b0};
    vecs[13] = '{2'd2, 3'd1, 0, 0, 900, 1'b0};
    vecs[14] = '{2'd2, 3'd1, 1, 0, 450, 1'b0};
    vecs[15] = '{2'd1, 3'd1, 0, 0, 900, 1'b0};
    vecs[16] = '{2'd1, 3'd0, 7, 7, 900, 1'b1};
    vecs[17] = '{2'd1, 3'd0, 6, 6, 900, 1'b1};
    vecs[18] = '{2'd1, 3'd1, 5, 6, 450, 1'b0};
    vecs[19] = '{2'd3, 3'd0, 5, 6, 450, 1'b0};
    vecs[20] = '{2'd3, 3'd0, 5, 6, 450, 1'b0};
    vecs[21] = '{2'd3, 3'd0, 5, 5, 900, 1'b0};

    rst_n = 1'b0; en = 1'b1; mode = 2'd0; shift = 3'd1;
    repeat (3) @(negedge clk);
    check("reset_led_out", 32'(led_out), 0);
    check("reset_head", 32'(head_idx), 0);
    check("reset_step_tick", 32'(step_tick), 0);

    rst_n = 1'b1;
    last_tick = cyc;
    for (int r = 0; r < NV; r++) begin
      mode  = vecs[r].mode;
      shift = vecs[r].shift;
      wait_tick($sformatf("tick_row%0d", r));
      check($sformatf("interval_row%0d", r), 32'(cyc - last_tick), SC);
      last_tick = cyc;
      check($sformatf("head_row%0d", r), 32'(head_idx), 32'(vecs[r].head));
      measure();
      check($sformatf("on_row%0d_ch%0d", r, vecs[r].ch), 32'(on_cnt[vecs[r].ch]), 32'(vecs[r].on));
      check($sformatf("tick_width_row%0d", r), 32'(win_ticks), 0);
      if (vecs[r].only_head) begin
        others = 0;
        for (int c = 0; c < N; c++) if (c != vecs[r].head) others += on_cnt[c];
        check($sformatf("tail_dark_row%0d", r), 32'(others), 0);
      end
    end

    // Asynchronous reset mid-step: outputs clear before any clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led_out", 32'(led_out), 0);
    check("async_rst_head", 32'(head_idx), 0);
    check("async_rst_step_tick", 32'(step_tick), 0);
    @(negedge clk);
    mode = 2'd0; shift = 3'd1;
    rst_n = 1'b1;
    last_tick = cyc;
    measure();
    others = 0;
    for (int c = 0; c < N; c++) others += on_cnt[c];
    check("post_rst_dark", 32'(others), 0);
    wait_tick("tick_post_rst");
    check("interval_post_rst", 32'(cyc - last_tick), SC);
    check("head_post_rst", 32'(head_idx), 1);

    // Enable drop mid-step: synchronous clear, held while en is low.
    repeat (100) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_low_led_out", 32'(led_out), 0);
    check("en_low_head", 32'(head_idx), 0);
    check("en_low_step_tick", 32'(step_tick), 0);
    repeat (4) @(negedge clk);
    check("en_low_hold_led_out", 32'(led_out), 0);
    check("en_low_hold_head", 32'(head_idx), 0);
    en = 1'b1;
    last_tick = cyc;
    wait_tick("tick_post_en");
    check("interval_post_en", 32'(cyc - last_tick), SC);
    check("head_post_en", 32'(head_idx), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
